robo_controlador: RTL and testbench
===================================

ROBO_CONTROLADOR -- requirements
Module: robo_controlador

Interface
REQ-001 The block SHALL have parameter DEB_CYCLES, default 3, giving consecutive identical samples needed to accept a sensor change; legal range 1..15.
REQ-002 The block SHALL have parameter ROT_MAX, default 16, giving the maximum clocks spent rotating before declaring a block; legal range 2..255.
REQ-003 The block SHALL have parameter LADO, default 0, selecting the followed wall: 0 = left, 1 = right.
REQ-004 clock  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 head  input  1  raw front-obstacle sensor, 1 = obstacle.
REQ-007 left  input  1  raw left-wall sensor, 1 = wall present.
REQ-008 right  input  1  raw right-wall sensor, 1 = wall present.
REQ-009 libera  input  1  single-cycle release pulse that leaves BLOQUEADO.
REQ-010 avancar  output  1  drive forward.
REQ-011 girar  output  1  rotate in place.
REQ-012 sentido  output  1  rotation direction, 1 = clockwise; constant, equal to ~LADO.
REQ-013 estado  output  2  current state code.
REQ-014 bloqueado  output  1  high while in BLOQUEADO.

Function
REQ-015 Each of head, left and right SHALL be filtered independently.
REQ-016 Each filtered value SHALL change only after its raw input differs from it on DEB_CYCLES consecutive rising edges; the counter clears on any edge where raw equals filtered.
REQ-017 The followed-side signal s SHALL be filtered left when LADO=0 and filtered right when LADO=1; h denotes filtered head.
REQ-018 The FSM SHALL have four states: PROCURANDO=2'b00, ROTACIONANDO=2'b01, ACOMPANHANDO=2'b10, BLOQUEADO=2'b11.
REQ-019 PROCURANDO: h=1 -> ROTACIONANDO; h=0 and s=1 -> ACOMPANHANDO; otherwise stay.
REQ-020 ROTACIONANDO: h=0 and s=1 -> ACOMPANHANDO; else if rotation count = ROT_MAX-1 -> BLOQUEADO; otherwise stay. The exit condition has priority over the timeout when both are true.
REQ-021 ACOMPANHANDO: h=1 -> ROTACIONANDO; h=0 and s=0 -> PROCURANDO; h=0 and s=1 -> stay.
REQ-022 BLOQUEADO: libera=1 -> PROCURANDO; otherwise stay, regardless of sensors.
REQ-023 libera SHALL be ignored in every state except BLOQUEADO.
REQ-024 The rotation counter SHALL load 0 on every transition into ROTACIONANDO and increment by 1 per clock while in ROTACIONANDO; the counter never wraps, so at most ROT_MAX clocks are spent in ROTACIONANDO.
REQ-025 Outputs SHALL be a Moore decode of the state register:
- PROCURANDO: avancar=1, girar=0
- ROTACIONANDO: avancar=0, girar=1
- ACOMPANHANDO: avancar=1, girar=0
- BLOQUEADO: avancar=0, girar=0, bloqueado=1
REQ-026 estado SHALL equal the state register; avancar and girar SHALL never both be 1.
REQ-027 A raw sensor change held stable SHALL reach the outputs in exactly DEB_CYCLES+1 rising edges: DEB_CYCLES edges for the filter, plus 1 edge for the state register.

Reset
REQ-028 While reset=0, and asynchronously on its falling edge, the block SHALL set:
- state = PROCURANDO
- filtered sensors = 0
- all debounce and rotation counters = 0
REQ-029 During and after reset the outputs SHALL be avancar=1, girar=0, bloqueado=0, estado=2'b00, sentido=~LADO.
REQ-030 Reset asserted mid-rotation or in BLOQUEADO SHALL abandon the state immediately; a pending libera is discarded.

Verification (DEB_CYCLES=3, ROT_MAX=8, LADO=0 unless stated)
REQ-031 Reset release with all sensors 0 -> estado=00, avancar=1, girar=0 held indefinitely.
REQ-032 Raise head for 2 clocks, then drop it -> no state change (glitch rejected). Hold head=1 -> estado=01 and girar=1 exactly 4 edges after head rose.
REQ-033 In ROTACIONANDO, drop head and raise left simultaneously and hold -> estado=10, avancar=1 after 4 edges. Then drop left -> estado=00 after 4 more edges.
REQ-034 Hold head=1 -> 8 clocks in 01, then estado=11, bloqueado=1, avancar=girar=0. Pulse libera while head is still 1 -> estado=00 next edge, then 01 after 1 further edge.
REQ-035 With LADO=1: raising left only -> stays 00; raising right only -> estado=10. sentido=0 throughout.
REQ-036 Assert reset asynchronously between edges while in 11 -> estado=00, bloqueado=0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/robo_controlador.sv
// Wall-following robot controller: debounced head/left/right sensors feed a
// four-state Moore FSM with a bounded rotation timer and a latched block state.
module robo_controlador #(
  parameter int DEB_CYCLES = 3,
  parameter int ROT_MAX    = 16,
  parameter bit LADO       = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       head,
  input  logic       left,
  input  logic       right,
  input  logic       libera,
  output logic       avancar,
  output logic       girar,
  output logic       sentido,
  output logic [1:0] estado,
  output logic       bloqueado
);

  typedef enum logic [1:0] {
    PROCURANDO   = 2'b00,
    ROTACIONANDO = 2'b01,
    ACOMPANHANDO = 2'b10,
    BLOQUEADO    = 2'b11
  } state_t;

  localparam logic [3:0] DEB_LAST = 4'(DEB_CYCLES - 1);
  localparam logic [7:0] ROT_LAST = 8'(ROT_MAX - 1);

  logic [2:0] raw_s;
  logic [2:0] filt_q, filt_d;
  logic [3:0] deb_cnt_q [3];
  logic [3:0] deb_cnt_d [3];
  logic [7:0] rot_cnt_q, rot_cnt_d;
  state_t     state_q, state_d;
  logic       avancar_q, avancar_d;
  logic       girar_q, girar_d;
  logic       bloqueado_q, bloqueado_d;
  logic       h_s, s_s;

  assign raw_s = {right, left, head};
  assign h_s   = filt_q[0];
  assign s_s   = LADO ? filt_q[2] : filt_q[1];

  // A filtered bit flips only after DEB_CYCLES consecutive disagreeing samples.
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < 3; i++) begin
      deb_cnt_d[i] = deb_cnt_q[i];
      if (raw_s[i] == filt_q[i]) begin
        deb_cnt_d[i] = 4'd0;
      end else if (deb_cnt_q[i] == DEB_LAST) begin
        filt_d[i]    = raw_s[i];
        deb_cnt_d[i] = 4'd0;
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + 4'd1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rot_cnt_d = rot_cnt_q;
    case (state_q)
      PROCURANDO: begin
        if (h_s) begin
          state_d   = ROTACIONANDO;
          rot_cnt_d = 8'd0;
        end else if (s_s) begin
          state_d = ACOMPANHANDO;
        end else begin
          state_d = PROCURANDO;
        end
      end
      ROTACIONANDO: begin
        // Finding the wall again wins over the timeout on the same edge.
        if (!h_s && s_s) begin
          state_d = ACOMPANHANDO;
        end else if (rot_cnt_q == ROT_LAST) begin
          state_d = BLOQUEADO;
        end else begin
          rot_cnt_d = rot_cnt_q + 8'd1;
        end
      end
      ACOMPANHANDO: begin
        if (h_s) begin
          state_d   = ROTACIONANDO;
          rot_cnt_d = 8'd0;
        end else if (!s_s) begin
          state_d = PROCURANDO;
        end else begin
          state_d = ACOMPANHANDO;
        end
      end
      BLOQUEADO: begin
        if (libera) begin
          state_d = PROCURANDO;
        end else begin
          state_d = BLOQUEADO;
        end
      end
      default: begin
        state_d   = PROCURANDO;
        rot_cnt_d = 8'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registers track state_q exactly.
  always_comb begin
    avancar_d   = 1'b0;
    girar_d     = 1'b0;
    bloqueado_d = 1'b0;
    case (state_d)
      PROCURANDO:   avancar_d   = 1'b1;
      ROTACIONANDO: girar_d     = 1'b1;
      ACOMPANHANDO: avancar_d   = 1'b1;
      BLOQUEADO:    bloqueado_d = 1'b1;
      default:      avancar_d   = 1'b1;
    endcase
  end

  // State, filter, counter and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= PROCURANDO;
      filt_q      <= 3'b000;
      rot_cnt_q   <= 8'd0;
      avancar_q   <= 1'b1;
      girar_q     <= 1'b0;
      bloqueado_q <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        deb_cnt_q[i] <= 4'd0;
      end
    end else begin
      state_q     <= state_d;
      filt_q      <= filt_d;
      rot_cnt_q   <= rot_cnt_d;
      avancar_q   <= avancar_d;
      girar_q     <= girar_d;
      bloqueado_q <= bloqueado_d;
      for (int i = 0; i < 3; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
      end
    end
  end

  assign avancar   = avancar_q;
  assign girar     = girar_q;
  assign bloqueado = bloqueado_q;
  assign estado    = state_q;
  assign sentido   = ~LADO;

endmodule

// File: tb/tb_robo_controlador.sv
// Bench for robo_controlador: two instances (left/right wall) share stimulus and
// are compared every cycle against a behavioural model plus directed constant checks.
module tb_robo_controlador;

  localparam int DEB  = 3;
  localparam int RMAX = 8;

  logic clock  = 1'b0;
  logic reset  = 1'b0;
  logic head   = 1'b0;
  logic left   = 1'b0;
  logic right  = 1'b0;
  logic libera = 1'b0;

  logic       av0, gi0, se0, bl0;
  logic       av1, gi1, se1, bl1;
  logic [1:0] es0, es1;

  int total = 0;
  int bad   = 0;

  // Model: filtered sensors, run lengths of disagreeing samples, per-instance state.
  bit mf   [3];
  int mrun [3];
  int mst  [2];
  int ment [2];
  int edge_n = 0;

  always #5 clock = ~clock;

  robo_controlador #(.DEB_CYCLES(DEB), .ROT_MAX(RMAX), .LADO(1'b0)) dut0 (
    .clock(clock), .reset(reset), .head(head), .left(left), .right(right),
    .libera(libera), .avancar(av0), .girar(gi0), .sentido(se0),
    .estado(es0), .bloqueado(bl0)
  );

  robo_controlador #(.DEB_CYCLES(DEB), .ROT_MAX(RMAX), .LADO(1'b1)) dut1 (
    .clock(clock), .reset(reset), .head(head), .left(left), .right(right),
    .libera(libera), .avancar(av1), .girar(gi1), .sentido(se1),
    .estado(es1), .bloqueado(bl1)
  );

  function automatic logic [5:0] expv(int st, bit lado);
    logic [1:0] code;
    code = 2'(st);
    return {code, 1'(st == 0 || st == 2), 1'(st == 1), 1'(st == 3), ~lado};
  endfunction

  task automatic check(string tag, logic [5:0] obs, logic [5:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mf[i]   = 1'b0;
      mrun[i] = 0;
    end
    mst[0] = 0;
    mst[1] = 0;
  endtask

  // One rising edge of the model; next state uses the filtered values from before the edge.
  task automatic model_step();
    bit raw [3];
    bit h, s;
    raw[0] = head;
    raw[1] = left;
    raw[2] = right;
    h = mf[0];
    for (int k = 0; k < 2; k++) begin
      s = (k == 1) ? mf[2] : mf[1];
      case (mst[k])
        0: if (h) begin mst[k] = 1; ment[k] = edge_n; end
           else if (s) mst[k] = 2;
        1: if (!h && s) mst[k] = 2;
           else if (edge_n - ment[k] == RMAX) mst[k] = 3;
        2: if (h) begin mst[k] = 1; ment[k] = edge_n; end
           else if (!s) mst[k] = 0;
        default: if (libera) mst[k] = 0;
      endcase
    end
    for (int i = 0; i < 3; i++) begin
      if (raw[i] == mf[i]) mrun[i] = 0;
      else mrun[i]++;
      if (mrun[i] == DEB) begin
        mf[i]   = raw[i];
        mrun[i] = 0;
      end
    end
    edge_n++;
  endtask

  task automatic compare_all(string tag);
    check({tag, "_l"}, {es0, av0, gi0, bl0, se0}, expv(mst[0], 1'b0));
    check({tag, "_r"}, {es1, av1, gi1, bl1, se1}, expv(mst[1], 1'b1));
  endtask

  task automatic tick(string tag);
    @(posedge clock);
    model_step();
    #1;
    compare_all(tag);
  endtask

  task automatic ticks(int n, string tag);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  task automatic async_reset(string tag);
    #2 reset = 1'b0;
    #1;
    model_reset();
    compare_all(tag);
    @(posedge clock);
    #1 reset = 1'b1;
  endtask

  initial begin
    model_reset();
    #12;
    compare_all("in_reset");
    check("in_reset_const", {es0, av0, gi0, bl0, se0}, 6'b00_1_0_0_1);
    @(posedge clock);
    #1 reset = 1'b1;

    ticks(6, "idle");
    check("idle_const", {es0, av0, gi0, bl0, se0}, 6'b00_1_0_0_1);

    head = 1'b1;
    ticks(2, "glitch");
    head = 1'b0;
    ticks(6, "glitch_drop");
    check("glitch_rejected", {4'b0000, es0}, 6'b000000);

    head = 1'b1;
    ticks(3, "head_filter");
    check("head_edge3", {4'b0000, es0}, 6'b000000);
    tick("head_edge4");
    check("rotate_after4", {es0, av0, gi0, bl0}, 5'b01_0_1_0);

    head = 1'b0;
    left = 1'b1;
    ticks(3, "find_wall");
    check("find_edge3", {4'b0000, es0}, 6'b000001);
    tick("find_edge4");
    check("follow_after4", {es0, av0, gi0, bl0}, 5'b10_1_0_0);

    left = 1'b0;
    ticks(4, "lose_wall");
    check("search_after4", {4'b0000, es0}, 6'b000000);

    head = 1'b1;
    ticks(4, "block_entry");
    check("block_rot_start", {4'b0000, es0}, 6'b000001);
    for (int i = 0; i < RMAX - 1; i++) begin
      tick("block_rot");
      check("block_still_rot", {4'b0000, es0}, 6'b000001);
    end
    tick("block_timeout");
    check("blocked", {es0, av0, gi0, bl0}, 5'b11_0_0_1);

    libera = 1'b1;
    tick("release");
    libera = 1'b0;
    check("released", {4'b0000, es0}, 6'b000000);
    tick("release_rot");
    check("release_rot", {4'b0000, es0}, 6'b000001);

    ticks(RMAX, "reblock");
    check("reblocked", {4'b0000, es0}, 6'b000011);
    libera = 1'b1;
    async_reset("async_rst");
    check("async_rst_const", {es0, av0, gi0, bl0}, 5'b00_1_0_0);
    libera = 1'b0;
    head   = 1'b0;

    left = 1'b1;
    ticks(6, "lado1_left");
    check("lado1_ignores_left", {4'b0000, es1}, 6'b000000);
    check("lado0_follows_left", {4'b0000, es0}, 6'b000010);
    left  = 1'b0;
    right = 1'b1;
    ticks(3, "lado1_right");
    check("lado1_right_edge3", {4'b0000, es1}, 6'b000000);
    tick("lado1_right_edge4");
    check("lado1_follows_right", {4'b0000, es1}, 6'b000010);
    check("lado1_sentido", {5'b00000, se1}, 6'b000000);
    right = 1'b0;
    ticks(4, "settle");

    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(5) == 0) head  = ~head;
      if ($urandom_range(5) == 0) left  = ~left;
      if ($urandom_range(5) == 0) right = ~right;
      libera = ($urandom_range(7) == 0);
      tick("random");
      libera = 1'b0;
      if (c == 700 || c == 1200) async_reset("random_rst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
